multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as listed below.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rstN  in  1  asynchronous active-low reset.
REQ-004 run  in  1  permits a new instruction fetch.
REQ-005 opCode  in  4  instruction-register opcode field; stable outside FETCH.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 memReady  in  1  memory completes the current read/write this cycle.
REQ-008 pcEn  out  1  PC load enable.
REQ-009 pcSource  out  1  PC source select: 0 = ALU result, 1 = ALUOut.
REQ-010 irWrite  out  1  instruction register load.
REQ-011 iorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-012 memRead, memWrite  out  1 each  memory strobes.
REQ-013 regDst, regWrite, memToReg  out  1 each  register-file controls.
REQ-014 aluSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
REQ-015 aluSrcB  out  2  ALU B select: 00 = rt, 01 = +1, 10 = offset, 11 = branch offset.
REQ-016 aluOp  out  3  ALU operation.
REQ-017 illegalOp  out  1  one-cycle pulse on an undefined opcode.
REQ-018 instrCount  out  16  retired-instruction count.

Function
REQ-019 States SHALL be: IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LD, MEM_WR, BRANCH, ILLEGAL.
REQ-020 Outputs SHALL be Moore-decoded from state; outputs not listed for a state are 0.
REQ-021 The only exceptions to REQ-020 SHALL be pcEn and irWrite, which also use the zero and memReady inputs.
REQ-022 IDLE SHALL assert no outputs and SHALL go to FETCH when run=1.
REQ-023 FETCH SHALL assert memRead with iorD=0, aluSrcA=0, aluSrcB=01, aluOp=010 and pcSource=0.
REQ-024 In FETCH, irWrite and pcEn SHALL be asserted only when memReady=1, and the state SHALL then go to DECODE; otherwise the state SHALL remain FETCH.
REQ-025 DECODE SHALL assert aluSrcA=0, aluSrcB=11 and aluOp=010.
REQ-026 DECODE SHALL branch as follows: 0000/0001/0010/0110/0111 to EXEC_R; 1000/1010 to ADDR; 1110 to BRANCH; any other opcode to ILLEGAL.
REQ-027 EXEC_R SHALL assert aluSrcA=1, aluSrcB=00 and aluOp=opCode[2:0], then go to WB_R.
REQ-028 WB_R SHALL assert regDst=1 and regWrite=1, with memToReg=0.
REQ-029 ADDR SHALL assert aluSrcA=1, aluSrcB=10 and aluOp=010, then go to MEM_RD if opCode=1000 or MEM_WR if opCode=1010.
REQ-030 MEM_RD SHALL assert memRead with iorD=1 and hold until memReady=1, then go to WB_LD.
REQ-031 WB_LD SHALL assert regWrite=1 and memToReg=1, with regDst=0.
REQ-032 MEM_WR SHALL assert memWrite with iorD=1 and hold until memReady=1; regWrite SHALL never be asserted for a store.
REQ-033 BRANCH SHALL assert aluSrcA=1, aluSrcB=00, aluOp=110 and pcSource=1, with pcEn = ~zero (taken branch only).
REQ-034 ILLEGAL SHALL pulse illegalOp for one cycle.
REQ-035 Terminal states (WB_R, WB_LD, MEM_WR on memReady, BRANCH, ILLEGAL) SHALL go to FETCH if run=1, else IDLE.
REQ-036 Deasserting run mid-instruction SHALL let the instruction complete before entering IDLE.
REQ-037 Zero-wait latency SHALL be: R-type 4 cycles, load 5, store 4, branch 3, illegal 3 (FETCH included).
REQ-038 instrCount SHALL increment by 1 on leaving each terminal state, excluding ILLEGAL, and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-039 While rstN=0, state SHALL be IDLE, instrCount SHALL be 0, and all strobes (pcEn, irWrite, memRead, memWrite, regWrite, illegalOp) SHALL be 0, independent of clk.
REQ-040 Reset asserted mid-memory-access SHALL drop memRead/memWrite immediately; there is no replay after release.
REQ-041 After rstN rises, the first FETCH SHALL occur one cycle after run=1 is sampled.

Structure
REQ-042 Shared package cpu_pkg SHALL hold the state enum, opcode constants, aluOp codes and aluSrcB encodings.
REQ-043 The block SHALL contain no sub-module: a single state register, next-state logic, output decode and the counter.

Verification
REQ-044 Reset, run=1, memReady=1, opCode=0010: state sequence FETCH, DECODE, EXEC_R, WB_R; regWrite=1 and regDst=1 in cycle 4; instrCount=1.
REQ-045 opCode=1000 with memReady low for 3 cycles in MEM_RD: memRead held 4 cycles with iorD=1; WB_LD has memToReg=1.
REQ-046 opCode=1110: zero=0 gives pcEn=1 with pcSource=1 in BRANCH; zero=1 gives pcEn=0.
REQ-047 opCode=1010: memWrite=1 until memReady; regWrite stays 0 for the whole instruction.
REQ-048 opCode=0100: illegalOp pulses for 1 cycle, then FETCH; instrCount unchanged.
REQ-049 rstN pulsed low during MEM_WR: memWrite=0 at once and state=IDLE. Separately, preload instrCount=0xFFFF and retire one instruction: instrCount=0x0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path.
// Holds FSM states, opcodes, ALU selects and the per-state control decode.
package cpu_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LD, MEM_WR, BRANCH, ILLEGAL
  } stateT;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BR  = 4'b1110;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_OFF   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  typedef struct packed {
    logic       pcSource;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       regDst;
    logic       regWrite;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       illegalOp;
  } ctrlT;

  function automatic stateT decodeTarget(input logic [3:0] op);
    stateT res;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: res = EXEC_R;
      OP_LW, OP_SW:                          res = ADDR;
      OP_BR:                                 res = BRANCH;
      default:                               res = ILLEGAL;
    endcase
    return res;
  endfunction

  // Moore controls for a state; unlisted fields stay 0.
  function automatic ctrlT mooreCtrl(input stateT s, input logic [3:0] op);
    ctrlT c;
    c = '0;
    case (s)
      FETCH:   begin c.memRead = 1'b1; c.aluSrcB = SRCB_ONE; c.aluOp = ALU_ADD; end
      DECODE:  begin c.aluSrcB = SRCB_BROFF; c.aluOp = ALU_ADD; end
      EXEC_R:  begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_RT; c.aluOp = op[2:0]; end
      WB_R:    begin c.regDst = 1'b1; c.regWrite = 1'b1; end
      ADDR:    begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_OFF; c.aluOp = ALU_ADD; end
      MEM_RD:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
      WB_LD:   begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
      MEM_WR:  begin c.memWrite = 1'b1; c.iorD = 1'b1; end
      BRANCH:  begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_RT; c.aluOp = ALU_SUB; c.pcSource = 1'b1; end
      ILLEGAL: c.illegalOp = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for the multicycle CPU.
// master = control FSM, slave = datapath side driving status and opcode.
interface multicycle_ctrl_if;
  logic        run;
  logic [3:0]  opCode;
  logic        zero;
  logic        memReady;
  logic        pcEn;
  logic        pcSource;
  logic        irWrite;
  logic        iorD;
  logic        memRead;
  logic        memWrite;
  logic        regDst;
  logic        regWrite;
  logic        memToReg;
  logic        aluSrcA;
  logic [1:0]  aluSrcB;
  logic [2:0]  aluOp;
  logic        illegalOp;
  logic [15:0] instrCount;

  modport master (
    input  run, opCode, zero, memReady,
    output pcEn, pcSource, irWrite, iorD, memRead, memWrite, regDst, regWrite,
           memToReg, aluSrcA, aluSrcB, aluOp, illegalOp, instrCount
  );

  modport slave (
    output run, opCode, zero, memReady,
    input  pcEn, pcSource, irWrite, iorD, memRead, memWrite, regDst, regWrite,
           memToReg, aluSrcA, aluSrcB, aluOp, illegalOp, instrCount
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing, Moore control
// decode registered alongside the state, and a retired-instruction counter.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  // Reset value of instrCount; nonzero only to start near the wrap point.
  parameter logic [15:0] COUNT_RST = 16'h0000
) (
  input logic               clk,
  input logic               rstN,
  multicycle_ctrl_if.master bus
);

  stateT       state;
  stateT       stateNxt;
  ctrlT        ctrlQ;
  logic [15:0] count;
  logic        retire;

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (bus.run) stateNxt = FETCH;
      FETCH:   if (bus.memReady) stateNxt = DECODE;
      DECODE:  stateNxt = decodeTarget(bus.opCode);
      EXEC_R:  stateNxt = WB_R;
      ADDR:    stateNxt = (bus.opCode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  if (bus.memReady) stateNxt = WB_LD;
      MEM_WR:  if (bus.memReady) stateNxt = bus.run ? FETCH : IDLE;
      WB_R, WB_LD, BRANCH, ILLEGAL: stateNxt = bus.run ? FETCH : IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // ILLEGAL is terminal but does not count as a retired instruction.
  assign retire = (state == WB_R) || (state == WB_LD) || (state == BRANCH) ||
                  ((state == MEM_WR) && bus.memReady);

  // Controls are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      ctrlQ <= '0;
      count <= COUNT_RST;
    end else begin
      state <= stateNxt;
      ctrlQ <= mooreCtrl(stateNxt, bus.opCode);
      if (retire) count <= count + 16'd1;
    end
  end

  // pcEn/irWrite must react to memReady/zero within the cycle.
  assign bus.irWrite    = (state == FETCH) && bus.memReady;
  assign bus.pcEn       = ((state == FETCH) && bus.memReady) ||
                          ((state == BRANCH) && !bus.zero);
  assign bus.pcSource   = ctrlQ.pcSource;
  assign bus.iorD       = ctrlQ.iorD;
  assign bus.memRead    = ctrlQ.memRead;
  assign bus.memWrite   = ctrlQ.memWrite;
  assign bus.regDst     = ctrlQ.regDst;
  assign bus.regWrite   = ctrlQ.regWrite;
  assign bus.memToReg   = ctrlQ.memToReg;
  assign bus.aluSrcA    = ctrlQ.aluSrcA;
  assign bus.aluSrcB    = ctrlQ.aluSrcB;
  assign bus.aluOp      = ctrlQ.aluOp;
  assign bus.illegalOp  = ctrlQ.illegalOp;
  assign bus.instrCount = count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instructions with a scoreboard queue,
// plus hand sequences for reset, fetch stall, run drop and counter wrap.
module tb_multicycle_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] cntModel;

  multicycle_ctrl_if bus ();
  multicycle_ctrl_if wrapBus ();

  multicycle_ctrl dut (.clk(clk), .rstN(rstN), .bus(bus));
  multicycle_ctrl #(.COUNT_RST(16'hFFFF)) wrapDut (.clk(clk), .rstN(rstN), .bus(wrapBus));

  assign wrapBus.run      = bus.run;
  assign wrapBus.opCode   = bus.opCode;
  assign wrapBus.zero     = bus.zero;
  assign wrapBus.memReady = bus.memReady;

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic       zero;
    int waits, lat, retire, regWr, m2r, memRd, memWr, brTaken, illegal;
  } vecT;

  typedef struct {
    int lat;
    logic [15:0] cnt;
    int regWr, m2r, memRd, memWr, brTaken, illegal;
  } expT;

  expT sb[$];
  vecT vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction starting at a negedge in FETCH; returns at the next FETCH.
  task automatic runInstr(input int idx, input vecT v);
    expT e;
    expT got;
    int  waitsDone;
    int  cyc;
    bit  done;
    e.lat = v.lat + v.waits;
    e.cnt = cntModel + 16'(v.retire);
    e.regWr = v.regWr; e.m2r = v.m2r; e.memRd = v.memRd;
    e.memWr = v.memWr; e.brTaken = v.brTaken; e.illegal = v.illegal;
    sb.push_back(e);
    cntModel = e.cnt;
    got.lat = 0; got.cnt = '0; got.regWr = 0; got.m2r = 0; got.memRd = 0;
    got.memWr = 0; got.brTaken = 0; got.illegal = 0;
    check($sformatf("v%0d start", idx), 32'(dut.state), 32'(FETCH));
    bus.opCode = v.op;
    bus.zero   = v.zero;
    waitsDone = 0;
    cyc = 0;
    done = 0;
    while (!done) begin
      if (dut.state inside {MEM_RD, MEM_WR}) begin
        bus.memReady = (waitsDone >= v.waits);
        waitsDone++;
      end else begin
        bus.memReady = 1'b1;
      end
      #1;
      if (bus.regWrite) got.regWr++;
      if (bus.memToReg) got.m2r++;
      if (bus.memRead && bus.iorD) got.memRd++;
      if (bus.memWrite) got.memWr++;
      if (bus.pcEn && bus.pcSource) got.brTaken++;
      if (bus.illegalOp) got.illegal++;
      @(negedge clk);
      cyc++;
      if (dut.state == FETCH || cyc >= 30) done = 1;
    end
    got.lat = cyc;
    got.cnt = bus.instrCount;
    e = sb.pop_front();
    check($sformatf("v%0d latency", idx), 32'(got.lat), 32'(e.lat));
    check($sformatf("v%0d instrCount", idx), 32'(got.cnt), 32'(e.cnt));
    check($sformatf("v%0d regWrite", idx), 32'(got.regWr), 32'(e.regWr));
    check($sformatf("v%0d memToReg", idx), 32'(got.m2r), 32'(e.m2r));
    check($sformatf("v%0d memRead", idx), 32'(got.memRd), 32'(e.memRd));
    check($sformatf("v%0d memWrite", idx), 32'(got.memWr), 32'(e.memWr));
    check($sformatf("v%0d branchTaken", idx), 32'(got.brTaken), 32'(e.brTaken));
    check($sformatf("v%0d illegalOp", idx), 32'(got.illegal), 32'(e.illegal));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sawWbLd;
    //            op       z     wt lat ret rW m2r mRd mWr br ill
    vecs[0]  = '{4'b0010, 1'b0, 0, 4, 1, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{4'b0000, 1'b0, 0, 4, 1, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{4'b0111, 1'b1, 0, 4, 1, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{4'b1000, 1'b0, 0, 5, 1, 1, 1, 1, 0, 0, 0};
    vecs[4]  = '{4'b1000, 1'b0, 3, 5, 1, 1, 1, 4, 0, 0, 0};
    vecs[5]  = '{4'b1010, 1'b0, 0, 4, 1, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{4'b1010, 1'b0, 2, 4, 1, 0, 0, 0, 3, 0, 0};
    vecs[7]  = '{4'b1110, 1'b0, 0, 3, 1, 0, 0, 0, 0, 1, 0};
    vecs[8]  = '{4'b1110, 1'b1, 0, 3, 1, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{4'b0100, 1'b0, 0, 3, 0, 0, 0, 0, 0, 0, 1};
    vecs[10] = '{4'b1111, 1'b0, 0, 3, 0, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{4'b0110, 1'b0, 0, 4, 1, 1, 0, 0, 0, 0, 0};

    bus.run = 1'b1; bus.opCode = 4'b0000; bus.zero = 1'b0; bus.memReady = 1'b0;
    cntModel = 16'h0000;

    // Reset held with run=1: nothing moves.
    repeat (3) @(negedge clk);
    #1;
    check("rst state", 32'(dut.state), 32'(IDLE));
    check("rst instrCount", 32'(bus.instrCount), 32'h0);
    check("rst strobes", 32'({bus.pcEn, bus.irWrite, bus.memRead, bus.memWrite,
                              bus.regWrite, bus.illegalOp}), 32'h0);
    check("rst preload", 32'(wrapBus.instrCount), 32'hFFFF);

    @(negedge clk);
    bus.run = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    check("idle1", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    check("idle2 memRead", 32'({dut.state == IDLE, bus.memRead}), 32'b10);

    // First FETCH one cycle after run; stall it with memReady low.
    bus.run = 1'b1;
    @(negedge clk);
    #1;
    check("fetch entry", 32'(dut.state), 32'(FETCH));
    check("fetch stall strobes", 32'({bus.memRead, bus.irWrite, bus.pcEn}), 32'b100);
    @(negedge clk);
    check("fetch held", 32'(dut.state), 32'(FETCH));
    bus.opCode = 4'b0010;
    bus.memReady = 1'b1;
    #1;
    check("fetch ready", 32'({bus.irWrite, bus.pcEn, bus.iorD, bus.pcSource, bus.aluSrcA}), 32'b11000);
    check("fetch alu", 32'({bus.aluSrcB, bus.aluOp}), 32'b01_010);
    @(negedge clk);
    check("decode", 32'({dut.state, bus.aluSrcA, bus.aluSrcB, bus.aluOp}),
          32'({DECODE, 1'b0, 2'b11, 3'b010}));
    @(negedge clk);
    check("exec_r", 32'({dut.state, bus.aluSrcA, bus.aluSrcB, bus.aluOp}),
          32'({EXEC_R, 1'b1, 2'b00, 3'b010}));
    @(negedge clk);
    check("wb_r", 32'({dut.state, bus.regWrite, bus.regDst, bus.memToReg}),
          32'({WB_R, 3'b110}));
    @(negedge clk);
    cntModel = 16'h0001;
    check("r count", 32'(bus.instrCount), 32'h1);
    check("wrap count", 32'(wrapBus.instrCount), 32'h0);
    check("r back to fetch", 32'(dut.state), 32'(FETCH));

    for (int i = 0; i < 12; i++) runInstr(i, vecs[i]);

    // Drop run mid-load: the load completes, then IDLE.
    bus.opCode = 4'b1000;
    bus.memReady = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    sawWbLd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dut.state == WB_LD) sawWbLd = 1;
      if (dut.state == IDLE) break;
    end
    cntModel = cntModel + 16'd1;
    check("rundrop wb_ld", 32'(sawWbLd), 32'h1);
    check("rundrop idle", 32'(dut.state), 32'(IDLE));
    check("rundrop count", 32'(bus.instrCount), 32'(cntModel));
    @(negedge clk);
    check("rundrop stays", 32'({dut.state == IDLE, bus.memRead}), 32'b10);

    // Reset during a stalled store.
    bus.run = 1'b1;
    bus.opCode = 4'b1010;
    @(negedge clk);
    check("restart fetch", 32'(dut.state), 32'(FETCH));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.memReady = 1'b0;
    #1;
    check("store stall", 32'({dut.state, bus.memWrite, bus.regWrite}), 32'({MEM_WR, 2'b10}));
    #2;
    rstN = 1'b0;
    #1;
    check("async rst memWrite", 32'({bus.memWrite, bus.memRead}), 32'b00);
    check("async rst state", 32'(dut.state), 32'(IDLE));
    check("async rst count", 32'(bus.instrCount), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    cntModel = 16'h0000;
    bus.memReady = 1'b1;
    @(negedge clk);
    check("no replay", 32'({dut.state, bus.memWrite}), 32'({FETCH, 1'b0}));

    runInstr(12, vecs[7]);
    check("wrap after reset", 32'(wrapBus.instrCount), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
